spi_rd_arb: RTL and testbench
=============================

# spi_rd_arb

Shared serial-read controller for the SPI-style input datapath. Arbitrates round-robin among NREQ requesters, runs one complete cs_n/sclk_n read frame per grant, shifts in WIDTH bits MSB-first from from_device, and returns the word with a one-cycle done pulse tagged by requester index. It sits between the internal consumers and the external serial device pins, and is the only driver of cs_n and sclk_n.

## Interface
- WIDTH, 8: bits per frame.
- NREQ, 4: number of requesters; must be ≥2.
- CLK_DIV, 2: clk cycles per sclk_n half-period; must be ≥1.
- CS_GAP, 2: clk cycles cs_n is held high after a frame before the next grant.
- clk  in  1  system clock, all logic on rising edge.
- rst_a  in  1  asynchronous, active-high reset.
- ena  in  1  global enable; low freezes the controller.
- req  in  NREQ  per-requester read request, level.
- gnt  out  NREQ  one-hot grant, high for the whole frame.
- busy  out  1  high from grant until return to IDLE.
- done  out  1  one-cycle pulse: rd_data valid for done_id.
- done_id  out  clog2(NREQ)  index of the requester served.
- rd_data  out  WIDTH  last received word, held until the next done.
- cs_n  out  1  device chip select, active low.
- sclk_n  out  1  serial clock, idles high.
- from_device  in  1  serial data from the device, treated as synchronous to clk.

## Operation
- Reset values: cs_n=1, sclk_n=1, gnt=0, busy=0, done=0, done_id=0, rd_data=0, rr pointer=0, state IDLE.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE: when ena=1 and req≠0, grant the first set req bit searching upward from the pointer, wrapping around. On the next edge, gnt is one-hot, cs_n=0, busy=1, and the state is SETUP. The pointer becomes (granted+1) mod NREQ.
- SETUP: cs_n low, sclk_n high for CLK_DIV cycles, then SHIFT.
- SHIFT: WIDTH sclk periods. Each period is sclk_n low for CLK_DIV cycles, then high for CLK_DIV cycles. from_device is sampled on the edge that drives sclk_n low→high and shifted in MSB first.
- End of SHIFT: on the edge after the last high phase, cs_n=1, gnt=0, done=1 for exactly one cycle, done_id=granted index, and rd_data=shift register. The state becomes GAP.
- GAP: sclk_n=1 and cs_n=1 for CS_GAP cycles, then IDLE. busy drops on entry to IDLE.
- ena=0 outside IDLE: all counters, state and outputs freeze. The frame resumes unchanged when ena returns to 1. A done pulse in progress is not extended.
- ena=0 in IDLE: no grant is issued, and pending req bits are ignored.
- A req dropped mid-frame does not abort the frame; done is still issued for that index.
- A request arriving mid-frame waits. No queueing beyond the req level is performed.
- rst_a asserted mid-frame immediately forces all reset values. cs_n goes high asynchronously, and no done is issued for the aborted frame.

## Timing
- T0 is the first cycle with gnt≠0. gnt, cs_n=0 and busy rise together at T0, one edge after req is seen in IDLE.
- First sclk_n fall: T0+CLK_DIV.
- Bit k (k=0 is MSB) is sampled at edge T0+CLK_DIV+2·CLK_DIV·k+CLK_DIV.
- done/cs_n rise: T0+CLK_DIV·(1+2·WIDTH). With defaults this is T0+34.
- busy falls at done+CS_GAP. The next gnt is earliest at done+CS_GAP+1. With defaults the frame-to-frame pitch is 37 cycles.
- gnt and done are never high in the same cycle.
- At most one gnt bit is high at any time.
- sclk_n only toggles while cs_n=0.

## Test plan
- Reset: assert rst_a for 2 cycles -> all outputs at reset values; cs_n=1 and sclk_n=1 during and after reset with req=0.
- Single read, defaults: req=4'b0001, device drives 8'hA5 MSB-first on sclk_n falls -> gnt=0001 at T0, 8 sclk_n low pulses, done at T0+34, done_id=0, rd_data=8'hA5.
- Round robin: req=4'b1111 held -> done_id sequence 0,1,2,3,0; done pulses 37 cycles apart.
- Skip and wrap: pointer=3 after serving index 2, req=4'b0101 -> next grant index 0, then index 2.
- ena stall: drop ena for 10 cycles after the 3rd sclk_n fall while reading 8'h3C -> done delayed by exactly 10 cycles, rd_data=8'h3C, no extra sclk_n edges.
- Reset mid-frame: assert rst_a at T0+15 -> cs_n=1 immediately, gnt=0, no done. After release, req=0001 starts a fresh frame with done at its T0+34.

Source files
------------

// File: rtl/spi_rd_arb.sv
// Round-robin arbiter in front of a single serial-read engine: one cs_n/sclk_n frame
// per grant, WIDTH bits shifted in MSB-first, word returned with a tagged done pulse.
module spi_rd_arb #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             ena,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic [WIDTH-1:0] rd_data,
    output logic             cs_n,
    output logic             sclk_n,
    input  logic             from_device
);
    localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, done_id_q, done_id_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             cs_n_q, cs_n_d, sclk_q, sclk_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] sh_q, sh_d, rd_q, rd_d;

    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic             cnt_end, gap_end, last_bit;
    int               j;

    // Walk offsets from high to low so the smallest offset from the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr_q) + i) % NREQ;
            if (req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(j);
            end
        end
    end

    assign cnt_end  = (cnt_q == CW'(CLK_DIV - 1));
    assign gap_end  = (cnt_q == CW'(CS_GAP - 1));
    assign last_bit = (bit_q == BW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            done_id_q <= '0;
            gnt_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sh_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            done_id_q <= done_id_d;
            gnt_q     <= gnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
        end
    end

    // In SHIFT, sclk_n high means the high half of the current bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        if (ena) begin
            unique case (state_q)
                IDLE: if (pick_vld) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end
                SETUP: if (cnt_end) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
                SHIFT: if (cnt_end) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        bit_d = bit_q + 1'b1;
                        if (last_bit) state_d = (CS_GAP == 0) ? IDLE : GAP;
                    end
                end else cnt_d = cnt_q + 1'b1;
                GAP: if (gap_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    // done self-clears even while frozen so a pulse never stretches.
    always_comb begin
        ptr_d     = ptr_q;
        id_d      = id_q;
        done_id_d = done_id_q;
        gnt_d     = gnt_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sh_d      = sh_q;
        rd_d      = rd_q;
        if (ena) begin
            unique case (state_q)
                IDLE: if (pick_vld) begin
                    gnt_d  = NREQ'(1) << pick_idx;
                    id_d   = pick_idx;
                    ptr_d  = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    cs_n_d = 1'b0;
                    busy_d = 1'b1;
                end
                SETUP: if (cnt_end) sclk_d = 1'b0;
                SHIFT: if (cnt_end) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sh_d   = WIDTH'({sh_q, from_device});
                    end else if (last_bit) begin
                        cs_n_d    = 1'b1;
                        gnt_d     = '0;
                        done_d    = 1'b1;
                        done_id_d = id_q;
                        rd_d      = sh_q;
                        busy_d    = (CS_GAP != 0);
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
                GAP: if (gap_end) busy_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign rd_data = rd_q;
    assign cs_n    = cs_n_q;
    assign sclk_n  = sclk_q;
endmodule

// File: tb/tb_spi_rd_arb.sv
// Bench for spi_rd_arb: transaction-level model (enabled-edge counting, RR pointer,
// serial device) checked every cycle, plus directed scenarios and a random soak.
module tb_spi_rd_arb;
    localparam int W = 8, N = 4, CD = 2, GAP = 2;
    localparam int FRAME = CD * (1 + 2 * W);
    localparam int M_IDLE = 0, M_FRAME = 1, M_GAP = 2;

    logic         clk = 1'b0, rst_a = 1'b1, ena = 1'b1, from_device = 1'b0;
    logic [N-1:0] req = '0, gnt;
    logic         busy, done, cs_n, sclk_n;
    logic [1:0]   done_id;
    logic [W-1:0] rd_data;

    spi_rd_arb #(.WIDTH(W), .NREQ(N), .CLK_DIV(CD), .CS_GAP(GAP)) dut (
        .clk(clk), .rst_a(rst_a), .ena(ena), .req(req), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .rd_data(rd_data), .cs_n(cs_n),
        .sclk_n(sclk_n), .from_device(from_device)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // model state
    int m = M_IDLE, ptr_m = 0, cur_id = 0, en_cnt = 0, gap_left = 0, falls = 0, idx = 0, cyc = 0;
    logic         prev_sclk = 1'b1;
    logic [W-1:0] dev_word = '0, force_word = '0;
    bit           force_en = 1'b0;
    int           done_ids[$], done_cyc[$], gnt_cyc[$];

    // Inputs seen at a negedge are the ones the preceding posedge used.
    always @(negedge clk) begin
        cyc++;
        if (rst_a) begin
            m = M_IDLE; ptr_m = 0; prev_sclk = 1'b1;
            chk("rst_cs_n", 32'(cs_n), 1);
            chk("rst_sclk_n", 32'(sclk_n), 1);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_done_id", 32'(done_id), 0);
            chk("rst_rd_data", 32'(rd_data), 0);
        end else begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            if (sclk_n !== prev_sclk) chk("sclk_needs_cs", 32'(cs_n), 0);
            if (prev_sclk && !sclk_n) begin
                falls++;
                if (falls <= W) from_device = dev_word[W - falls];
            end
            prev_sclk = sclk_n;
            case (m)
                M_IDLE: if (ena && req != 0) begin
                    idx = 0;
                    for (int i = N - 1; i >= 0; i--) if (req[(ptr_m + i) % N]) idx = (ptr_m + i) % N;
                    chk("grant", 32'(gnt), 32'(1 << idx));
                    chk("grant_cs_n", 32'(cs_n), 0);
                    chk("grant_busy", 32'(busy), 1);
                    cur_id = idx; ptr_m = (idx + 1) % N; en_cnt = 0; falls = 0;
                    dev_word = force_en ? force_word : W'($urandom);
                    gnt_cyc.push_back(cyc);
                    m = M_FRAME;
                end else begin
                    chk("idle_gnt", 32'(gnt), 0);
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_done", 32'(done), 0);
                end
                M_FRAME: begin
                    if (ena) en_cnt++;
                    if (en_cnt == FRAME) begin
                        chk("done", 32'(done), 1);
                        chk("done_id", 32'(done_id), 32'(cur_id));
                        chk("rd_data", 32'(rd_data), 32'(dev_word));
                        chk("done_gnt", 32'(gnt), 0);
                        chk("done_cs_n", 32'(cs_n), 1);
                        chk("sclk_falls", 32'(falls), W);
                        done_ids.push_back(cur_id);
                        done_cyc.push_back(cyc);
                        gap_left = GAP;
                        m = (GAP == 0) ? M_IDLE : M_GAP;
                    end else begin
                        chk("frame_done", 32'(done), 0);
                        chk("frame_gnt", 32'(gnt), 32'(1 << cur_id));
                        chk("frame_busy", 32'(busy), 1);
                        chk("frame_cs_n", 32'(cs_n), 0);
                    end
                end
                default: begin
                    if (ena) gap_left--;
                    chk("gap_done", 32'(done), 0);
                    chk("gap_cs_n", 32'(cs_n), 1);
                    chk("gap_gnt", 32'(gnt), 0);
                    if (gap_left == 0) begin
                        chk("gap_busy_fall", 32'(busy), 0);
                        m = M_IDLE;
                    end else chk("gap_busy", 32'(busy), 1);
                end
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_dones(input int target, input int budget);
        int t = 0;
        while (done_ids.size() < target && t < budget) begin step(1); t++; end
        chk("done_timeout", 32'(done_ids.size()), 32'(target));
    endtask

    task automatic wait_gnts(input int target, input int budget);
        int t = 0;
        while (gnt_cyc.size() < target && t < budget) begin step(1); t++; end
        chk("gnt_timeout", 32'(gnt_cyc.size()), 32'(target));
    endtask

    int base, rq_cyc, nd;

    initial begin
        // reset held for 2 cycles, then idle with req=0
        step(2);
        rst_a = 1'b0;
        step(4);

        // single read of A5 from requester 0
        force_en = 1'b1; force_word = 8'hA5;
        req = 4'b0001; rq_cyc = cyc;
        wait_gnts(1, 10);
        chk("req_to_gnt", 32'(gnt_cyc[0] - rq_cyc), 1);
        req = '0;
        wait_dones(1, 60);
        chk("single_lat", 32'(done_cyc[0] - gnt_cyc[0]), 34);
        chk("single_id", 32'(done_ids[0]), 0);
        chk("single_data", 32'(rd_data), 8'hA5);
        step(5);

        // round robin from a freshly reset pointer
        rst_a = 1'b1; step(2); rst_a = 1'b0; step(1);
        force_en = 1'b0;
        base = done_ids.size();
        req = 4'b1111;
        wait_dones(base + 5, 250);
        req = '0;
        for (int k = 0; k < 5; k++) chk("rr_id", 32'(done_ids[base + k]), 32'(k % N));
        for (int k = 1; k < 5; k++) chk("rr_pitch", 32'(done_cyc[base + k] - done_cyc[base + k - 1]), 37);

        // serve 2 (pointer -> 3), then 0101 must wrap to 0 before 2
        base = done_ids.size();
        req = 4'b0100;
        wait_dones(base + 1, 60);
        chk("skip_first", 32'(done_ids[base]), 2);
        req = 4'b0101;
        wait_dones(base + 3, 120);
        req = '0;
        chk("wrap_id0", 32'(done_ids[base + 1]), 0);
        chk("wrap_id2", 32'(done_ids[base + 2]), 2);
        step(5);

        // ena stall after the third sclk_n fall
        force_en = 1'b1; force_word = 8'h3C;
        base = done_ids.size(); nd = gnt_cyc.size();
        req = 4'b0001;
        wait_gnts(nd + 1, 10);
        req = '0;
        for (int t = 0; t < 40 && falls < 3; t++) step(1);
        chk("stall_falls", 32'(falls), 3);
        ena = 1'b0; step(10); ena = 1'b1;
        wait_dones(base + 1, 80);
        chk("stall_lat", 32'(done_cyc[base] - gnt_cyc[nd]), 44);
        chk("stall_data", 32'(rd_data), 8'h3C);
        step(5);

        // reset at T0+15 aborts the frame with no done
        force_en = 1'b0;
        nd = gnt_cyc.size();
        req = 4'b0001;
        wait_gnts(nd + 1, 10);
        step(14);
        base = done_ids.size();
        rst_a = 1'b1;
        #1;
        chk("abort_cs_n", 32'(cs_n), 1);
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_done", 32'(done), 0);
        step(2);
        rst_a = 1'b0;
        nd = gnt_cyc.size();
        wait_gnts(nd + 1, 10);
        req = '0;
        chk("abort_no_done", 32'(done_ids.size()), 32'(base));
        wait_dones(base + 1, 60);
        chk("fresh_lat", 32'(done_cyc[base] - gnt_cyc[nd]), 34);
        chk("fresh_id", 32'(done_ids[base]), 0);

        // random soak: req levels and ena drops, model checks every cycle
        base = done_ids.size();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(7) == 0) req = N'($urandom);
            ena = ($urandom_range(9) != 0);
            step(1);
        end
        req = '0; ena = 1'b1;
        step(60);
        chk("rand_progress", 32'(done_ids.size() - base > 20), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
